// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction sequencer: fetches over a req/ack
// handshake, holds the instruction during execute, and applies branch/flag updates.
module fetch_sequencer #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               halt,
    input  logic               take_branch,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               flag_we,
    input  logic               alu_zero,
    input  logic               alu_positive,
    output logic               prev_zero_flag,
    output logic               prev_positive_flag,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus_1,
    output logic               halted,
    output logic [CNT_W-1:0]   retire_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;

    // A retiring instruction is one that completes without halting.
    logic exec_fire;
    logic retire;
    logic resume;

    assign exec_fire = (state == EXEC) && exec_done;
    assign retire    = exec_fire && !halt;
    assign resume    = (state == HALT) && start;

    assign pc_plus_1   = pc + PC_W'(1);
    assign imem_addr   = pc;
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALT);

    // NOTE: next_state gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (imem_ack) next_state = EXEC;
            EXEC:    if (exec_done) next_state = halt ? HALT : FETCH;
            HALT:    if (start) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (retire) begin
            pc <= take_branch ? branch_target : pc_plus_1;
        end else if (resume) begin
            pc <= pc_plus_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
        end else if ((state == FETCH) && imem_ack) begin
            instr <= imem_rdata;
        end
    end

    // Flags written by instruction N are only visible to N+1 onwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_zero_flag     <= 1'b0;
            prev_positive_flag <= 1'b0;
        end else if (retire && flag_we) begin
            prev_zero_flag     <= alu_zero;
            prev_positive_flag <= alu_positive;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (retire && (retire_count != {CNT_W{1'b1}})) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer: per-cycle input/expected
// records plus a hand-written reset-abort sequence.
module tb_fetch_sequencer;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               exec_done;
    logic               halt;
    logic               take_branch;
    logic [PC_W-1:0]    branch_target;
    logic               flag_we;
    logic               alu_zero;
    logic               alu_positive;
    logic               prev_zero_flag;
    logic               prev_positive_flag;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus_1;
    logic               halted;
    logic [CNT_W-1:0]   retire_count;

    fetch_sequencer #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .halt(halt), .take_branch(take_branch),
        .branch_target(branch_target), .flag_we(flag_we),
        .alu_zero(alu_zero), .alu_positive(alu_positive),
        .prev_zero_flag(prev_zero_flag), .prev_positive_flag(prev_positive_flag),
        .pc(pc), .pc_plus_1(pc_plus_1), .halted(halted),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               st;
        logic               ack;
        logic [INSTR_W-1:0] rdata;
        logic               done;
        logic               hlt;
        logic               tb;
        logic [PC_W-1:0]    tgt;
        logic               fwe;
        logic               az;
        logic               ap;
        logic               e_req;
        logic               e_val;
        logic               e_hlt;
        logic [PC_W-1:0]    e_pc;
        logic [CNT_W-1:0]   e_rc;
        logic               e_zf;
        logic               e_pf;
        logic [INSTR_W-1:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(
        input logic st, input logic ack, input logic [INSTR_W-1:0] rdata,
        input logic done, input logic hlt, input logic tb, input logic [PC_W-1:0] tgt,
        input logic fwe, input logic az, input logic ap,
        input logic e_req, input logic e_val, input logic e_hlt, input logic [PC_W-1:0] e_pc,
        input logic [CNT_W-1:0] e_rc, input logic e_zf, input logic e_pf,
        input logic [INSTR_W-1:0] e_instr);
        vec_t v;
        v.st = st; v.ack = ack; v.rdata = rdata; v.done = done; v.hlt = hlt;
        v.tb = tb; v.tgt = tgt; v.fwe = fwe; v.az = az; v.ap = ap;
        v.e_req = e_req; v.e_val = e_val; v.e_hlt = e_hlt; v.e_pc = e_pc;
        v.e_rc = e_rc; v.e_zf = e_zf; v.e_pf = e_pf; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        start = 0; imem_ack = 0; imem_rdata = '0; exec_done = 0; halt = 0;
        take_branch = 0; branch_target = '0; flag_we = 0; alu_zero = 0; alu_positive = 0;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        logic [PC_W-1:0] exp_pp;
        exp_pp = v.e_pc + 10'd1;
        check({tag, ".imem_req"},    32'(imem_req),           32'(v.e_req));
        check({tag, ".instr_valid"}, 32'(instr_valid),        32'(v.e_val));
        check({tag, ".halted"},      32'(halted),             32'(v.e_hlt));
        check({tag, ".pc"},          32'(pc),                 32'(v.e_pc));
        check({tag, ".imem_addr"},   32'(imem_addr),          32'(v.e_pc));
        check({tag, ".pc_plus_1"},   32'(pc_plus_1),          32'(exp_pp));
        check({tag, ".retire"},      32'(retire_count),       32'(v.e_rc));
        check({tag, ".zero_flag"},   32'(prev_zero_flag),     32'(v.e_zf));
        check({tag, ".pos_flag"},    32'(prev_positive_flag), 32'(v.e_pf));
        check({tag, ".instr"},       32'(instr),              32'(v.e_instr));
    endtask

    initial begin
        vec_t r;
        // st ack rdata  dn hl tb tgt    we az ap | req val hlt pc     rc  zf pf instr
        push(1, 0, 16'h0,    0, 0, 0, 10'h0,   0, 0, 0,  0, 0, 0, 10'h000, 0,  0, 0, 16'h0000); // 0 IDLE
        push(0, 1, 16'h1000, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h000, 0,  0, 0, 16'h0000); // 1 FETCH 0
        push(0, 0, 16'h0,    1, 0, 0, 10'h0,   0, 0, 0,  0, 1, 0, 10'h000, 0,  0, 0, 16'h1000);
        push(0, 1, 16'h1001, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h001, 1,  0, 0, 16'h1000);
        push(0, 0, 16'h0,    1, 0, 0, 10'h0,   0, 0, 0,  0, 1, 0, 10'h001, 1,  0, 0, 16'h1001);
        push(0, 1, 16'h1002, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h002, 2,  0, 0, 16'h1001);
        push(0, 0, 16'h0,    1, 0, 0, 10'h0,   0, 0, 0,  0, 1, 0, 10'h002, 2,  0, 0, 16'h1002);
        push(0, 1, 16'h1003, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h003, 3,  0, 0, 16'h1002);
        push(0, 0, 16'h0,    1, 0, 0, 10'h0,   0, 0, 0,  0, 1, 0, 10'h003, 3,  0, 0, 16'h1003);
        push(0, 1, 16'h2004, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h004, 4,  0, 0, 16'h1003); // 9 rc=4
        push(0, 0, 16'h0,    1, 0, 0, 10'h0,   1, 1, 0,  0, 1, 0, 10'h004, 4,  0, 0, 16'h2004); // flag write
        push(0, 1, 16'h2005, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h005, 5,  1, 0, 16'h2004);
        push(0, 0, 16'h0,    1, 0, 1, 10'h3F0, 0, 0, 1,  0, 1, 0, 10'h005, 5,  1, 0, 16'h2005); // branch, fwe=0
        push(0, 1, 16'h3F00, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h3F0, 6,  1, 0, 16'h2005);
        push(0, 0, 16'h0,    1, 0, 1, 10'h3FF, 1, 0, 1,  0, 1, 0, 10'h3F0, 6,  1, 0, 16'h3F00);
        push(0, 1, 16'h3FF0, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h3FF, 7,  0, 1, 16'h3F00);
        push(0, 0, 16'h0,    1, 0, 0, 10'h0,   0, 0, 0,  0, 1, 0, 10'h3FF, 7,  0, 1, 16'h3FF0); // wrap
        push(0, 1, 16'h0A0A, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h000, 8,  0, 1, 16'h3FF0);
        push(0, 0, 16'h0,    1, 0, 1, 10'h007, 0, 0, 0,  0, 1, 0, 10'h000, 8,  0, 1, 16'h0A0A);
        push(0, 1, 16'h7777, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h007, 9,  0, 1, 16'h0A0A);
        push(0, 0, 16'h0,    1, 1, 1, 10'h100, 1, 1, 1,  0, 1, 0, 10'h007, 9,  0, 1, 16'h7777); // halt wins
        push(0, 1, 16'h1111, 1, 0, 1, 10'h200, 1, 1, 0,  0, 0, 1, 10'h007, 9,  0, 1, 16'h7777); // HALT, ignored
        push(1, 0, 16'h0,    0, 0, 0, 10'h0,   0, 0, 0,  0, 0, 1, 10'h007, 9,  0, 1, 16'h7777);
        push(0, 0, 16'h0,    1, 0, 1, 10'h300, 1, 1, 1,  1, 0, 0, 10'h008, 9,  0, 1, 16'h7777); // resume at 8
        push(0, 1, 16'h8888, 0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h008, 9,  0, 1, 16'h7777);
        push(1, 1, 16'hDEAD, 0, 0, 0, 10'h0,   0, 0, 0,  0, 1, 0, 10'h008, 9,  0, 1, 16'h8888); // EXEC waits
        push(0, 0, 16'h0,    1, 0, 0, 10'h0,   0, 0, 0,  0, 1, 0, 10'h008, 9,  0, 1, 16'h8888);
        push(0, 0, 16'h0,    0, 0, 0, 10'h0,   0, 0, 0,  1, 0, 0, 10'h009, 10, 0, 1, 16'h8888);

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        r.e_req = 0; r.e_val = 0; r.e_hlt = 0; r.e_pc = '0; r.e_rc = '0;
        r.e_zf = 0; r.e_pf = 0; r.e_instr = '0;
        check_outputs("reset", r);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start = vecs[i].st; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            exec_done = vecs[i].done; halt = vecs[i].hlt; take_branch = vecs[i].tb;
            branch_target = vecs[i].tgt; flag_we = vecs[i].fwe;
            alu_zero = vecs[i].az; alu_positive = vecs[i].ap;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Ack withheld: request and address must stay put, then reset aborts mid-FETCH.
        drive_idle();
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (c == 3) begin
                rst_n = 1'b0;
                #1;
                check("abort.imem_req", 32'(imem_req), 32'(0));
                check("abort.pc", 32'(pc), 32'(0));
                check("abort.retire", 32'(retire_count), 32'(0));
                check("abort.instr", 32'(instr), 32'(0));
                check("abort.halted", 32'(halted), 32'(0));
                @(negedge clk);
                rst_n = 1'b1;
                imem_ack = 1'b1; imem_rdata = 16'hBEEF;
                break;
            end
            check($sformatf("stall%0d.imem_req", c), 32'(imem_req), 32'(1));
            check($sformatf("stall%0d.imem_addr", c), 32'(imem_addr), 32'(10'h009));
            @(negedge clk);
        end
        repeat (2) begin
            @(negedge clk);
            check("late_ack.imem_req", 32'(imem_req), 32'(0));
            check("late_ack.instr_valid", 32'(instr_valid), 32'(0));
            check("late_ack.instr", 32'(instr), 32'(0));
        end
        imem_ack = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart.imem_req", 32'(imem_req), 32'(1));
        check("restart.imem_addr", 32'(imem_addr), 32'(0));
        imem_ack = 1'b1; imem_rdata = 16'h5A5A;
        @(negedge clk);
        imem_ack = 1'b0;
        check("restart.instr_valid", 32'(instr_valid), 32'(1));
        check("restart.instr", 32'(instr), 32'(16'h5A5A));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
